// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: sequencer for one convolution pass.
// Issues one IFMAP pixel address per cycle in raster order (x, then y, then
// channel). It tags the addresses that close a FILTER_W x FILTER_W window,
// delays each tag by MAC_LAT cycles and uses it to drive accumulator-clear
// and feature-RAM write control toward the PE array.
// Optional feature macro: CONV_SCAN_CTRL_PERF_EN adds the perf_cycles busy counter.
module conv_scan_ctrl #(
  parameter int IFMAP_H  = 5,
  parameter int IFMAP_W  = 5,
  parameter int IFMAP_C  = 1,
  parameter int FILTER_W = 3,
  parameter int MAC_LAT  = 2,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              image_ram_re,
  output logic [ADDR_W-1:0] image_ram_addr,
  output logic              acc_clr,
  output logic              win_valid,
  output logic              feature_ram_we,
  output logic [ADDR_W-1:0] feature_ram_addr
`ifdef CONV_SCAN_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam int XW = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1;
  localparam int YW = (IFMAP_H > 1) ? $clog2(IFMAP_H) : 1;
  localparam int CW = (IFMAP_C > 1) ? $clog2(IFMAP_C) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IFMAP_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IFMAP_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IFMAP_C - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(FILTER_W - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(FILTER_W - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  // Tag travelling alongside each issued address until the PE result appears.
  typedef struct packed {
    logic              win;
    logic              c0;
    logic              clast;
    logic [ADDR_W-1:0] cnt;
  } tag_t;

  state_t                  state;
  logic [XW-1:0]           x;
  logic [YW-1:0]           y;
  logic [CW-1:0]           c;
  logic [ADDR_W-1:0]       win_cnt;
  logic [DW-1:0]           dcnt;
  tag_t                    tag_in;
  tag_t                    last;
  tag_t [MAC_LAT-1:0]      pipe;

  // Tag of the address presented this cycle; win only while a read is issued.
  always_comb begin
    tag_in       = '0;
    tag_in.win   = image_ram_re && (x >= X_WIN) && (y >= Y_WIN);
    tag_in.c0    = (c == '0);
    tag_in.clast = (c == C_LAST);
    tag_in.cnt   = win_cnt;
  end

  // Control FSM with scan counters; a stall freezes SCAN and DRAIN completely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      c              <= '0;
      win_cnt        <= '0;
      dcnt           <= '0;
      image_ram_re   <= 1'b0;
      image_ram_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= SCAN;
            image_ram_re   <= 1'b1;
            image_ram_addr <= '0;
            busy           <= 1'b1;
            x              <= '0;
            y              <= '0;
            c              <= '0;
            win_cnt        <= '0;
          end
        end
        SCAN: begin
          if (!stall) begin
            image_ram_addr <= image_ram_addr + ADDR_W'(1);
            if (tag_in.win) win_cnt <= win_cnt + ADDR_W'(1);
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y       <= '0;
                win_cnt <= '0;
                if (c == C_LAST) begin
                  // Final pixel consumed: stop reading, let the MAC pipe empty.
                  c              <= '0;
                  state          <= DRAIN;
                  image_ram_re   <= 1'b0;
                  image_ram_addr <= '0;
                  dcnt           <= '0;
                end else begin
                  c <= c + CW'(1);
                end
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (dcnt == D_LAST) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MAC latency match: tags shift one stage per non-stalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (!stall) begin
      pipe[0] <= tag_in;
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Result-side outputs; gated by stall so a frozen tag never writes twice.
  assign last             = pipe[MAC_LAT-1];
  assign win_valid        = last.win & ~stall;
  assign acc_clr          = win_valid & last.c0;
  assign feature_ram_we   = win_valid & last.clast;
  assign feature_ram_addr = win_valid ? last.cnt : '0;

`ifdef CONV_SCAN_CTRL_PERF_EN
  // Busy-cycle counter: cleared on start accept, saturating, held after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 16'hFFFF) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Testbench for conv_scan_ctrl: a default (C=1) instance and a C=2 instance,
// exercised with directed passes and random stalls against an event-order
// reference model of the pass.
module tb_conv_scan_ctrl;
  localparam int H = 5, W = 5, F = 3, ML = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, stall;

  logic       busy0, done0, re0, acc0, wv0, we0;
  logic [4:0] a0, fa0;
  logic       busy1, done1, re1, acc1, wv1, we1;
  logic [5:0] a1, fa1;
`ifdef CONV_SCAN_CTRL_PERF_EN
  logic [15:0] pf0, pf1;
`endif

  int total = 0, bad = 0;
  int s_busy, s_done, s_re, s_acc, s_wv, s_we, s_addr, s_fa, s_perf;

  always #5 clk = ~clk;

  conv_scan_ctrl #(.IFMAP_H(H), .IFMAP_W(W), .IFMAP_C(1), .FILTER_W(F),
                   .MAC_LAT(ML), .ADDR_W(5)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .stall(stall[0]),
    .busy(busy0), .done(done0), .image_ram_re(re0), .image_ram_addr(a0),
    .acc_clr(acc0), .win_valid(wv0), .feature_ram_we(we0), .feature_ram_addr(fa0)
`ifdef CONV_SCAN_CTRL_PERF_EN
    , .perf_cycles(pf0)
`endif
  );

  conv_scan_ctrl #(.IFMAP_H(H), .IFMAP_W(W), .IFMAP_C(2), .FILTER_W(F),
                   .MAC_LAT(ML), .ADDR_W(6)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .stall(stall[1]),
    .busy(busy1), .done(done1), .image_ram_re(re1), .image_ram_addr(a1),
    .acc_clr(acc1), .win_valid(wv1), .feature_ram_we(we1), .feature_ram_addr(fa1)
`ifdef CONV_SCAN_CTRL_PERF_EN
    , .perf_cycles(pf1)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic st, input logic sl);
    start    = '0;
    stall    = '0;
    start[d] = st;
    stall[d] = sl;
  endtask

  task automatic samp(input int d);
    if (d == 0) begin
      s_busy = busy0; s_done = done0; s_re = re0; s_acc = acc0;
      s_wv = wv0; s_we = we0; s_addr = int'(a0); s_fa = int'(fa0);
`ifdef CONV_SCAN_CTRL_PERF_EN
      s_perf = int'(pf0);
`endif
    end else begin
      s_busy = busy1; s_done = done1; s_re = re1; s_acc = acc1;
      s_wv = wv1; s_we = we1; s_addr = int'(a1); s_fa = int'(fa1);
`ifdef CONV_SCAN_CTRL_PERF_EN
      s_perf = int'(pf1);
`endif
    end
  endtask

  task automatic chk_all_zero(input string tag, input int d);
    samp(d);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_done"}, s_done, 0);
    chk({tag, "_re"},   s_re, 0);
    chk({tag, "_addr"}, s_addr, 0);
    chk({tag, "_wv"},   s_wv, 0);
    chk({tag, "_we"},   s_we, 0);
    chk({tag, "_acc"},  s_acc, 0);
    chk({tag, "_fa"},   s_fa, 0);
  endtask

  // mode 0: no stall, 1: random stall, 2: stall 3 cycles while addr==7.
  task automatic run_pass(input int d, input int C, input int mode, input bit hold);
    int n, nw, fwaddr, i, j, cyc, bcyc, nst, at7;
    int t_fa, t_la, t_fw, t_lw, t_dn;
    bit got_done;
    logic sl;
    int wacc[$], wwe[$], wfa[$];
    n = H * W * C;
    // Expected windows in raster order: (acc_clr, we, per-channel index).
    for (int cc = 0; cc < C; cc++) begin
      int k = 0;
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++)
          if (xx >= F - 1 && yy >= F - 1) begin
            wacc.push_back(cc == 0);
            wwe.push_back(cc == C - 1);
            wfa.push_back(k);
            k++;
          end
    end
    nw = wacc.size();
    fwaddr = (C - 1) * H * W + (F - 1) * W + (F - 1);
    i = 0; j = 0; cyc = 0; bcyc = 0; nst = 0; at7 = 0;
    t_fa = -1; t_la = -1; t_fw = -1; t_lw = -1; t_dn = -1;
    got_done = 0;

    @(posedge clk); #1; set_in(d, 1'b1, 1'b0);
    for (int k = 0; k < 3000 && !got_done; k++) begin
      @(posedge clk); #1;
      samp(d);
      case (mode)
        1:       sl = ($urandom_range(0, 3) == 0);
        2:       sl = (s_re == 1 && s_addr == 7 && nst < 3);
        default: sl = 1'b0;
      endcase
      set_in(d, hold, sl);
      #1;
      samp(d);
      cyc++;
      if (s_busy == 1) begin
        bcyc++;
        if (sl) nst++;
      end
      if (s_re == 1 && s_addr == 7) at7++;
      if (s_re == 1 && !sl) begin
        chk("issue_addr", s_addr, i);
        if (i == fwaddr) t_fa = cyc;
        if (i == n - 1) t_la = cyc;
        i++;
      end
      if (s_wv == 1) begin
        if (j < nw) begin
          chk("win_acc_clr", s_acc, wacc[j]);
          chk("win_we", s_we, wwe[j]);
          chk("win_faddr", s_fa, wfa[j]);
        end else begin
          chk("win_extra", j, nw - 1);
        end
        if (s_we == 1) begin
          if (t_fw < 0) t_fw = cyc;
          t_lw = cyc;
        end
        j++;
      end else begin
        chk("nowin_we", s_we, 0);
        chk("nowin_acc", s_acc, 0);
        chk("nowin_fa", s_fa, 0);
      end
      if (sl) chk("wv_while_stalled", s_wv, 0);
      if (s_done == 1) begin
        got_done = 1;
        t_dn = cyc;
        chk("busy_at_done", s_busy, 0);
`ifdef CONV_SCAN_CTRL_PERF_EN
        chk("perf_cycles", s_perf, bcyc);
        if (mode == 2 && C == 1) chk("perf_30", s_perf, 30);
`endif
      end
    end
    chk("done_seen", got_done, 1);
    chk("issue_count", i, n);
    chk("window_count", j, nw);
    chk("busy_cycles", bcyc, n + ML + nst);
    if (mode == 0) begin
      chk("first_we_latency", t_fw - t_fa, ML);
      chk("last_we_latency", t_lw - t_la, ML);
      chk("done_latency", t_dn - t_la, ML + 1);
    end
    if (mode == 2) chk("addr7_hold_cycles", at7, 4);
    if (!hold) begin
      @(posedge clk); #1; set_in(d, 1'b0, 1'b0); #1;
      samp(d);
      chk("done_one_cycle", s_done, 0);
      chk("idle_busy", s_busy, 0);
      chk("idle_re", s_re, 0);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start = '0;
    stall = '0;
    #1;
    chk_all_zero("reset0", 0);
    chk_all_zero("reset1", 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_pass(0, 1, 0, 1'b0);
    run_pass(1, 2, 0, 1'b0);
    run_pass(0, 1, 2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_pass(0, 1, 1, 1'b0);
      run_pass(1, 2, 1, 1'b0);
    end

    // Reset mid-pass: abort at addr 15, no done, then a clean restart.
    @(posedge clk); #1; set_in(0, 1'b1, 1'b0);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1; set_in(0, 1'b0, 1'b0); #1;
      samp(0);
      if (s_re == 1 && s_addr == 15) seen = 1;
    end
    chk("reached_addr15", seen, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midpass_reset", 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      samp(0);
      chk("no_done_in_reset", s_done, 0);
    end
    rst = 1'b0;
    run_pass(0, 1, 0, 1'b0);

    // Start held high: one pass, idle for one cycle, then the next pass.
    run_pass(0, 1, 0, 1'b1);
    @(posedge clk); #1; set_in(0, 1'b1, 1'b0); #1;
    samp(0);
    chk("hold_idle_busy", s_busy, 0);
    chk("hold_idle_re", s_re, 0);
    chk("hold_idle_done", s_done, 0);
    @(posedge clk); #1; set_in(0, 1'b0, 1'b0); #1;
    samp(0);
    chk("hold_restart_re", s_re, 1);
    chk("hold_restart_addr", s_addr, 0);
    chk("hold_restart_busy", s_busy, 1);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #2;
      samp(0);
      if (s_done == 1) seen = 1;
    end
    chk("hold_second_done", seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
